adder_4bit: RTL and testbench
=============================

// Module: adder_4bit
// PURPOSE
//   Unsigned 4-bit binary adder producing a 4-bit sum and a carry-out.
//   Built as a ripple-carry chain of full-adder cells, with a registered output stage.
//   Used as the partial-product accumulation element of the 4x4 multiplier datapath.
//   One clock; asynchronous active-low reset.
// PARAMETERS
//   WIDTH    4   operand/sum width in bits; the 4x4 multiplier uses the default only
// PORTS
//   clk        input   1      rising-edge clock
//   rst_n      input   1      asynchronous active-low reset
//   in_valid   input   1      A/B qualify this cycle; sampled on the clk rising edge
//   A          input   WIDTH  addend, unsigned
//   B          input   WIDTH  addend, unsigned
//   Sum        output  WIDTH  registered (A+B) mod 2^WIDTH
//   Carry      output  1      registered carry-out, bit WIDTH of A+B
//   out_valid  output  1      Sum/Carry hold a result captured from a valid input
// BEHAVIOUR
//   - Reset: the design uses one clock, and reset is asynchronous and active-low.
//     - While rst_n=0, Sum=0, Carry=0 and out_valid=0, independent of clk.
//     - Deassertion takes effect at the next rising clk edge.
//   - Datapath: a combinational ripple chain of WIDTH full adders.
//     - Carry-in to bit 0 is tied to 0.
//     - s[i] = a[i]^b[i]^c[i]
//     - c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i])
//     - {Carry,Sum} = A + B, as a WIDTH+1-bit unsigned result; there is no truncation
//       apart from Carry taking bit WIDTH.
//   - Latency is 1 cycle. On each rising clk edge with in_valid=1:
//     - Sum and Carry load the combinational result.
//     - out_valid is set to 1 on that edge.
//   - On a rising clk edge with in_valid=0:
//     - Sum and Carry hold their previous values.
//     - out_valid is cleared to 0.
//   - There is no backpressure. A new valid operand pair is accepted every cycle, so
//     throughput is one add per clock.
//   - Boundaries:
//     - 15+15 gives Sum=4'b1110, Carry=1.
//     - 0+0 gives Sum=0, Carry=0.
//     - 8+8 gives Sum=0, Carry=1 (wrap to zero with carry).
//   - Reset mid-operation clears the outputs and out_valid immediately. The pending
//     capture is discarded, and there are no partial results.
//   - Outputs never glitch between edges, because they come only from flops.
//   - X/Z on A or B while in_valid=0 must not propagate to the outputs.
// TESTING
//   1. Reset: assert rst_n=0 mid-cycle with prior Sum=4'hF.
//      -> Sum=0, Carry=0 and out_valid=0 immediately, without waiting for clk.
//   2. Exhaustive: drive {B,A}=i for i=0..255 with in_valid=1, one pair per cycle.
//      -> One cycle later, {Carry,Sum}==A+B for every pair; out_valid=1 throughout.
//   3. Corners, each checked one cycle later:
//      - A=4'b1111, B=4'b0001 -> Sum=0000, Carry=1
//      - A=4'b1111, B=4'b1111 -> Sum=1110, Carry=1
//      - A=0101, B=1010 -> Sum=1111, Carry=0
//   4. Hold: add 3+4, then drop in_valid and change A=9, B=9.
//      -> Sum stays 0111, Carry stays 0, out_valid goes 0 on the next edge.
//   5. Back-to-back: the sequence (1,1), (7,9), (8,8) on consecutive edges.
//      -> Outputs 0010/0, then 0000/1, then 0000/1 on consecutive cycles.
//   6. Reset during stream: pull rst_n low between two valid adds.
//      -> The outputs return to 0. After release, the first valid pair is seen
//         exactly one cycle later.

Source files
------------

// File: rtl/adder_4bit.sv
// Unsigned ripple-carry adder with a registered sum/carry stage and valid flag.
// Feeds the partial-product accumulation of the 4x4 multiplier datapath.
module adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  // Result flops load only on valid input, so idle-cycle operand values never reach them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum   <= s;
        Carry <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// Directed-vector bench for adder_4bit: reset, exhaustive sweep, corners, hold,
// back-to-back and reset during a stream.
module tb_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [3:0] sum;
  logic       carry;
  logic       out_valid;

  int n_checks;
  int n_errors;

  adder_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a_in),
    .B         (b_in),
    .Sum       (sum),
    .Carry     (carry),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] e_sum, input logic e_carry,
                           input logic e_valid);
    check_val({tag, ".sum"},   {28'd0, sum},       {28'd0, e_sum});
    check_val({tag, ".carry"}, {31'd0, carry},     {31'd0, e_carry});
    check_val({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e_valid});
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b);
    in_valid = v;
    a_in     = a;
    b_in     = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] exp5;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0);
    #2;
    check_out("reset_init", 4'h0, 1'b0, 1'b0);
    tick();
    check_out("reset_held", 4'h0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // Test 1: async reset mid-cycle with Sum=F
    drive(1'b1, 4'hF, 4'h0);
    tick();
    check_out("pre_reset", 4'hF, 1'b0, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check_out("async_reset", 4'h0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    // Test 2: exhaustive sweep, one pair per cycle
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, i[3:0], i[7:4]);
      exp5 = {1'b0, i[3:0]} + {1'b0, i[7:4]};
      tick();
      check_out($sformatf("exh%0d", i), exp5[3:0], exp5[4], 1'b1);
    end

    // Test 3: corners
    drive(1'b1, 4'b1111, 4'b0001); tick(); check_out("f_plus_1", 4'b0000, 1'b1, 1'b1);
    drive(1'b1, 4'b1111, 4'b1111); tick(); check_out("f_plus_f", 4'b1110, 1'b1, 1'b1);
    drive(1'b1, 4'b0101, 4'b1010); tick(); check_out("5_plus_a", 4'b1111, 1'b0, 1'b1);
    drive(1'b1, 4'd0,    4'd0);    tick(); check_out("0_plus_0", 4'b0000, 1'b0, 1'b1);
    drive(1'b1, 4'd8,    4'd8);    tick(); check_out("8_plus_8", 4'b0000, 1'b1, 1'b1);

    // Test 4: hold while in_valid is low, including unknown operands
    drive(1'b1, 4'd3, 4'd4); tick(); check_out("hold_load", 4'b0111, 1'b0, 1'b1);
    drive(1'b0, 4'd9, 4'd9); tick(); check_out("hold_1",    4'b0111, 1'b0, 1'b0);
    drive(1'b0, 4'hx, 4'hx); tick(); check_out("hold_x",    4'b0111, 1'b0, 1'b0);

    // Test 5: back-to-back
    drive(1'b1, 4'd1, 4'd1); tick(); check_out("b2b_1", 4'b0010, 1'b0, 1'b1);
    drive(1'b1, 4'd7, 4'd9); tick(); check_out("b2b_2", 4'b0000, 1'b1, 1'b1);
    drive(1'b1, 4'd8, 4'd8); tick(); check_out("b2b_3", 4'b0000, 1'b1, 1'b1);

    // Test 6: reset between two valid adds discards the pending capture
    drive(1'b1, 4'd2, 4'd3); tick(); check_out("strm_pre", 4'd5, 1'b0, 1'b1);
    drive(1'b1, 4'd4, 4'd5);
    #3 rst_n = 1'b0;
    #1;
    check_out("strm_rst", 4'd0, 1'b0, 1'b0);
    tick();
    check_out("strm_rst_edge", 4'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    drive(1'b1, 4'd6, 4'd7);
    tick();
    check_out("strm_post", 4'hD, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 4'd0);
    tick();
    check_out("strm_idle", 4'hD, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
